fp_addsub_seq: RTL
==================

// Module: fp_addsub_seq
// PURPOSE
//  Issue/collect sequencer directly upstream and downstream of the fp_add_sub adder in the RISC-V F datapath.
//  Accepts FADD.S/FSUB.S ops with a destination tag (valid/ready) and registers the operands onto the adder inputs.
//  Tracks in-flight ops over the adder's fixed latency and captures each result, with its tag, into an output FIFO.
//  Credit-based admission ensures no adder result is ever dropped for lack of space.
// PARAMETERS
//  TAG_W      5  width of destination-register tag
//  ADD_LAT    1  adder latency: edges from operand registers to valid adder result (fp_add_sub = 1)
//  OUT_DEPTH  4  output FIFO entries, power of 2, >= ADD_LAT+1
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      synchronous kill of all in-flight and queued ops
//  in_valid   in   1      op request valid
//  in_ready   out  1      op request may be accepted this cycle
//  in_a       in   32     operand A, IEEE-754 single
//  in_b       in   32     operand B, IEEE-754 single
//  in_op      in   2      00 add, 01 sub; in_op[1] ignored
//  in_tag     in   TAG_W  destination tag
//  add_a      out  32     to adder a
//  add_b      out  32     to adder b
//  add_op     out  2      to adder op_mode, always {1'b0,in_op[0]}
//  add_result in   32     from adder result
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_data   out  32     result
//  out_tag    out  TAG_W  tag of result
// BEHAVIOUR
//  Interface: reset is asynchronous, active-high; clock is clk.
//  Reset values: in_ready=0 while reset asserted, 1 after; add_a/add_b/add_op=0; out_valid=0; out_data/out_tag=0; counters and FIFO empty.
//  Accept on in_valid&in_ready. At that edge, operands are registered onto add_*. A valid/tag shift register of ADD_LAT+1 stages is loaded.
//  The adder samples add_* at the next edge. After ADD_LAT edges, the shift-register tail is set and add_result is valid.
//  At the following edge, {add_result,tag} is pushed into the FIFO.
//  Accept-to-out_valid latency is ADD_LAT+1 cycles (2 by default). Back-to-back accepts give one result per cycle.
//  Credit: in_ready = !flush && (inflight + fifo_count) < OUT_DEPTH.
//  inflight counts set shift-register bits. The counter is updated for simultaneous accept/push/pop in the same cycle.
//  out_valid = FIFO non-empty; pop on out_valid&out_ready. out_data/out_tag are FIFO head, stable while out_valid&!out_ready.
//  FIFO full and out_ready=0: credit holds in_ready=0 and no push can overflow.
//  Empty FIFO plus push: result is visible the next cycle (no fall-through).
//  flush: at that edge, clears the FIFO and shift-register valids; no accept that cycle; add_* hold value.
//  A result arriving at the flush edge is discarded.
//  Reset asserted mid-operation: all state returns to reset values immediately; in-flight ops are lost.
// CONFIGURATION
//  Macro FP_ADDSUB_SEQ_FLAGS_EN defined: adds output out_flags[4:0] = {NV,DZ,OF,UF,NX}, FIFO-aligned with out_data.
//   NV=1 if either operand is sNaN (exp FF, frac!=0, frac[22]=0) or result==7FC00000 with no NaN operand.
//   OF=NX=1 if result exp==FF, frac==0, and neither operand is inf/NaN. DZ=UF=0.
//   Operand classes are piped alongside the tag.
//  Undefined: no out_flags port, no flag storage; FIFO width is 32+TAG_W.
// STRUCTURE
//  Package fp_addsub_pkg: OP_ADD/OP_SUB codes, QNAN=32'h7FC00000, EXP_MAX=8'hFF, flag bit indices, class-decode functions.
//  Sub-module fp_result_fifo: sync FIFO, parameters WIDTH/DEPTH, push/pop/clear, count output.
//  Top level holds the operand registers, tag/valid shift register, inflight counter and credit logic.
// TESTING
//  Add: 3F800000 + 40000000, op 00, tag 3 -> out_valid 2 cycles after accept, out_data 40400000, out_tag 3.
//  Sub streaming: 40400000 - 3F800000 (tag 1), then 40A00000 - 40A00000 (tag 2) back-to-back.
//   Expected: 40000000/1 then 00000000/2 on consecutive cycles.
//  Backpressure: out_ready=0, issue 4 ops -> in_ready=0 after 4th accept and 5th held.
//   Then out_ready=1 -> results in order, in_ready reasserts, no loss.
//  Flush: issue 2 ops, flush one cycle later -> no out_valid ever for them; a next op accepted after flush returns normally.
//  Reset mid-op: assert reset with 2 in flight and 1 queued -> out_valid=0 immediately; after release only new ops appear.
//  FLAGS_EN: 7F800001 + 3F800000 -> 7FC00000, flags 10000; 7F7FFFFF + 7F7FFFFF -> 7F800000, flags 00101.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg
//   Shared definitions for the fp_addsub_seq issue/collect sequencer.
//   - op_e           : adder operation codes (add / sub)
//   - QNAN, EXP_MAX  : IEEE-754 single constants used by flag derivation
//   - FLG_*          : bit positions inside the {NV,DZ,OF,UF,NX} flag vector
//   - cls_t          : operand-pair class bits carried alongside each op
//   - is_nan / is_snan / is_inf_or_nan / pair_class / result_flags helpers
package fp_addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01
   } op_e;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   localparam int unsigned FLG_NX = 0;
   localparam int unsigned FLG_UF = 1;
   localparam int unsigned FLG_OF = 2;
   localparam int unsigned FLG_DZ = 3;
   localparam int unsigned FLG_NV = 4;

   // Class summary of the two operands of one op.
   typedef struct packed {
      logic any_nan;
      logic any_snan;
      logic any_infnan;
   } cls_t;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == EXP_MAX) && (x[22:0] != '0);
   endfunction

   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction

   function automatic logic is_inf_or_nan(input logic [31:0] x);
      return x[30:23] == EXP_MAX;
   endfunction

   function automatic cls_t pair_class(input logic [31:0] a, input logic [31:0] b);
      cls_t c;
      c.any_nan    = is_nan(a) || is_nan(b);
      c.any_snan   = is_snan(a) || is_snan(b);
      c.any_infnan = is_inf_or_nan(a) || is_inf_or_nan(b);
      return c;
   endfunction

   // The adder reports no flags itself, so they are reconstructed from the
   // operand classes and the result: invalid for sNaN inputs or a freshly
   // generated default NaN, overflow (always inexact) for an infinite result
   // produced from finite operands.
   function automatic logic [4:0] result_flags(input cls_t c, input logic [31:0] r);
      logic [4:0] f;
      logic       ovf;
      f         = '0;
      ovf       = (r[30:23] == EXP_MAX) && (r[22:0] == '0) && !c.any_infnan;
      f[FLG_NV] = c.any_snan || ((r == QNAN) && !c.any_nan);
      f[FLG_DZ] = 1'b0;
      f[FLG_OF] = ovf;
      f[FLG_UF] = 1'b0;
      f[FLG_NX] = ovf;
      return f;
   endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo
//   Synchronous FIFO for adder results. Head is presented combinationally
//   from storage (no fall-through: a push into an empty FIFO is visible the
//   cycle after the push edge). pop_data reads as zero while empty.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     clear           synchronous flush of all entries (wins over push/pop)
//     push, push_data write one entry (ignored when full)
//     pop             remove head entry (ignored when empty)
//     pop_data        head entry
//     empty           no entries stored
//     count           number of stored entries
module fp_result_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: it is only observable through pop_data, which
   // is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq
//   Issue/collect sequencer around the fixed-latency fp_add_sub adder.
//   Accepted FADD.S/FSUB.S ops are registered onto the adder inputs; a
//   valid/tag shift register follows each op through the adder latency and
//   the result is captured with its tag into an output FIFO. Admission is
//   credit based (in-flight + queued < OUT_DEPTH), so no result is dropped.
//   Optional feature macro: FP_ADDSUB_SEQ_FLAGS_EN adds out_flags[4:0]
//   ({NV,DZ,OF,UF,NX}) stored in the FIFO alongside each result.
//   Ports:
//     clk, reset                      clock, asynchronous active-high reset
//     flush                           synchronous kill of in-flight/queued ops
//     in_valid/in_ready               op request handshake
//     in_a, in_b, in_op, in_tag       operands, op (bit 0: sub), dest tag
//     add_a, add_b, add_op            registered adder inputs
//     add_result                      adder output
//     out_valid/out_ready             result handshake
//     out_data, out_tag [, out_flags] FIFO head
module fp_addsub_seq
   import fp_addsub_pkg::*;
#(
   parameter int unsigned TAG_W     = 5,
   parameter int unsigned ADD_LAT   = 1,
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   output logic [1:0]       add_op,
   input  logic [31:0]      add_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
   ,
   output logic [4:0]       out_flags
`endif
);

   localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
   localparam int unsigned FIFO_W = 32 + TAG_W + 5;
`else
   localparam int unsigned FIFO_W = 32 + TAG_W;
`endif

   logic [31:0]      add_a_q, add_a_d;
   logic [31:0]      add_b_q, add_b_d;
   op_e              add_op_q, add_op_d;
   logic [ADD_LAT:0] sr_vld_q, sr_vld_d;
   logic [TAG_W-1:0] sr_tag_q [ADD_LAT+1];
   logic [TAG_W-1:0] sr_tag_d [ADD_LAT+1];
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
   cls_t             sr_cls_q [ADD_LAT+1];
   cls_t             sr_cls_d [ADD_LAT+1];
`endif
   logic [CNT_W-1:0] inflight_q, inflight_d;

   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credit_used;
   logic [FIFO_W-1:0] push_data;
   logic [FIFO_W-1:0] pop_data;
   logic              unused_op_hi;

   // Only bit 0 of the op selects add/sub; bit 1 is deliberately dropped.
   assign unused_op_hi = in_op[1];

   assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
   assign in_ready    = !reset && !flush && (credit_used < (CNT_W+1)'(OUT_DEPTH));
   assign accept      = in_valid && in_ready;
   // The shift-register tail marks the cycle add_result is valid; a result
   // arriving on a flush edge is discarded.
   assign push        = sr_vld_q[ADD_LAT] && !flush;
   assign pop         = out_valid && out_ready;

   always_comb begin
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
      add_op_d = add_op_q;
      if (accept) begin
         add_a_d  = in_a;
         add_b_d  = in_b;
         add_op_d = in_op[0] ? OP_SUB : OP_ADD;
      end

      sr_vld_d    = '0;
      sr_vld_d[0] = accept;
      sr_tag_d[0] = accept ? in_tag : sr_tag_q[0];
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
      sr_cls_d[0] = accept ? pair_class(in_a, in_b) : sr_cls_q[0];
`endif
      for (int unsigned i = 1; i <= ADD_LAT; i++) begin
         sr_vld_d[i] = sr_vld_q[i-1];
         sr_tag_d[i] = sr_tag_q[i-1];
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
         sr_cls_d[i] = sr_cls_q[i-1];
`endif
      end
      if (flush) sr_vld_d = '0;

      // Ops enter at stage 0 and leave from the tail; the tail leaving is
      // exactly the push into the FIFO, so in-flight + queued only drops on pop.
      if (flush) inflight_d = '0;
      else       inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(sr_vld_q[ADD_LAT]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_op_q   <= OP_ADD;
         sr_vld_q   <= '0;
         inflight_q <= '0;
         for (int unsigned i = 0; i <= ADD_LAT; i++) begin
            sr_tag_q[i] <= '0;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
            sr_cls_q[i] <= '0;
`endif
         end
      end else begin
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_op_q   <= add_op_d;
         sr_vld_q   <= sr_vld_d;
         inflight_q <= inflight_d;
         sr_tag_q   <= sr_tag_d;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
         sr_cls_q   <= sr_cls_d;
`endif
      end
   end

   assign add_a  = add_a_q;
   assign add_b  = add_b_q;
   assign add_op = add_op_q;

`ifdef FP_ADDSUB_SEQ_FLAGS_EN
   assign push_data = {add_result, sr_tag_q[ADD_LAT], result_flags(sr_cls_q[ADD_LAT], add_result)};
   assign {out_data, out_tag, out_flags} = pop_data;
`else
   assign push_data = {add_result, sr_tag_q[ADD_LAT]};
   assign {out_data, out_tag} = pop_data;
`endif

   fp_result_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;

endmodule
